// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - digit/control inputs and scanned display outputs of seg7_scan
interface seg7_scan_if;
  logic [15:0] i_digits;
  logic [3:0]  i_dp;
  logic [3:0]  i_blink_mask;
  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_frame;

  modport master (
    output i_digits, i_dp, i_blink_mask,
    input  o_an, o_seg, o_dp, o_frame
  );

  modport slave (
    input  i_digits, i_dp, i_blink_mask,
    output o_an, o_seg, o_dp, o_frame
  );
endinterface

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - 4-digit multiplexed 7-segment scanner with frame snapshots
// Optional blinking compiled in with SEG7_BLINK_EN.
module seg7_scan #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 64,
  parameter int LZ_BLANK  = 1
) (
  input logic        i_clk,
  input logic        i_rst_n,
  seg7_scan_if.slave bus
);
  localparam int DW = $clog2(SCAN_DIV);

  logic [DW-1:0] div_cnt;
  logic [1:0]    idx;
  logic [15:0]   snap_digits;
  logic [3:0]    snap_dp;
  logic          slot_end;
  logic          frame_end;
  logic [3:0]    cur_digit;
  logic          z3, z2, z1;
  logic          lz;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  assign slot_end  = (div_cnt == DW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx == 2'd3);

`ifdef SEG7_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] frame_cnt;
  logic          blink_phase;
  logic [3:0]    snap_blink;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      snap_blink  <= 4'h0;
    end else if (frame_end) begin
      snap_blink <= bus.i_blink_mask;
      if (frame_cnt == BW'(BLINK_DIV - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^bus.i_blink_mask;
`endif

  // Leading-zero chain: a digit blanks only when it and every digit above it are zero.
  always_comb begin
    cur_digit = snap_digits[{idx, 2'b00} +: 4];
    z3 = (snap_digits[15:12] == 4'h0);
    z2 = z3 && (snap_digits[11:8] == 4'h0);
    z1 = z2 && (snap_digits[7:4] == 4'h0);
    lz = 1'b0;
    if (LZ_BLANK != 0) begin
      case (idx)
        2'd3:    lz = z3;
        2'd2:    lz = z2;
        2'd1:    lz = z1;
        default: lz = 1'b0;
      endcase
    end
    seg_nxt = lz ? 7'h7F : glyph(cur_digit);
    dp_nxt  = ~snap_dp[idx];
`ifdef SEG7_BLINK_EN
    if (blink_phase && snap_blink[idx]) begin
      seg_nxt = 7'h7F;
      dp_nxt  = 1'b1;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt     <= '0;
      idx         <= 2'd0;
      snap_digits <= 16'h0000;
      snap_dp     <= 4'h0;
      bus.o_an    <= 4'hF;
      bus.o_seg   <= 7'h7F;
      bus.o_dp    <= 1'b1;
      bus.o_frame <= 1'b0;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end) idx <= idx + 2'd1;
      if (frame_end) begin
        snap_digits <= bus.i_digits;
        snap_dp     <= bus.i_dp;
      end
      bus.o_frame <= frame_end;
      // Anodes stay off for the first cycle of each slot so segments settle before enabling.
      bus.o_an    <= (div_cnt == '0) ? 4'hF : ~(4'b0001 << idx);
      bus.o_seg   <= seg_nxt;
      bus.o_dp    <= dp_nxt;
    end
  end
endmodule
